// File: rtl/moldudp64_pkg.sv
// Shared widths, constants and header classification for the MoldUDP64
// multi-channel gap/session tracker.
package moldudp64_pkg;

    localparam int          DEF_SID_W       = 80;
    localparam int          DEF_SEQ_NUM_W   = 64;
    localparam int          DEF_ML_W        = 16;
    localparam logic [15:0] DEF_EOS_MSG_CNT = 16'hffff;

    // Outcome of comparing one header against one channel's tracked state.
    typedef enum logic [2:0] {
        CAPT     = 3'd0,  // channel had no state: header seeds it
        OK       = 3'd1,  // in-order (or clean session rollover)
        MISS_SEQ = 3'd2,  // gap inside the current session
        MISS_SID = 3'd3,  // jump to a later session
        DUP      = 3'd4,  // starts below the expected seq (retransmit/dup)
        STALE    = 3'd5   // older session, or same session after EOS
    } hdr_cls_e;

    // Stale headers are dropped outright; every other class is accepted
    // and may therefore close the session when it carries the EOS marker.
    function automatic logic cls_accepts(input hdr_cls_e cls);
        return (cls != STALE);
    endfunction

endpackage

// File: rtl/moldudp64_hdr_cmp.sv
// Combinational classifier: one channel's tracked state plus one packet
// header in, classification, next channel state and report fields out.
module moldudp64_hdr_cmp
    import moldudp64_pkg::*;
#(
    parameter int              SID_W       = DEF_SID_W,
    parameter int              SEQ_NUM_W   = DEF_SEQ_NUM_W,
    parameter int              ML_W        = DEF_ML_W,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = ML_W'(DEF_EOS_MSG_CNT)
) (
    input  logic                 st_vld,
    input  logic                 st_eos,
    input  logic [SID_W-1:0]     st_sid,
    input  logic [SEQ_NUM_W-1:0] st_exp,
    input  logic [SID_W-1:0]     hdr_sid,
    input  logic [SEQ_NUM_W-1:0] hdr_seq_num,
    input  logic [ML_W-1:0]      hdr_msg_cnt,
    output hdr_cls_e             cls,
    output logic                 hdr_eos,
    output logic                 nxt_eos,
    output logic [SID_W-1:0]     nxt_sid,
    output logic [SEQ_NUM_W-1:0] nxt_exp,
    output logic [SEQ_NUM_W-1:0] seq_gap,
    output logic [SID_W-1:0]     sid_gap
);

    logic [SEQ_NUM_W-1:0] inc_s;
    logic [SEQ_NUM_W-1:0] end_s;
    logic                 rollover_s;
    logic                 base_eos_s;

    // Packet extent: an EOS packet carries no messages, so it does not advance.
    always_comb begin
        hdr_eos = (hdr_msg_cnt == EOS_MSG_CNT);
        if (hdr_eos) begin
            inc_s = {SEQ_NUM_W{1'b0}};
        end else begin
            inc_s = SEQ_NUM_W'(hdr_msg_cnt);
        end
        end_s      = hdr_seq_num + inc_s;
        seq_gap    = hdr_seq_num - st_exp;
        sid_gap    = hdr_sid - st_sid;
        rollover_s = st_eos && (hdr_sid == (st_sid + SID_W'(1)))
                     && (hdr_seq_num == SEQ_NUM_W'(1));
    end

    // Classification and next-state selection; stale headers leave state as is.
    always_comb begin
        cls        = OK;
        base_eos_s = st_eos;
        nxt_sid    = st_sid;
        nxt_exp    = st_exp;
        if (!st_vld) begin
            cls        = CAPT;
            base_eos_s = 1'b0;
            nxt_sid    = hdr_sid;
            nxt_exp    = end_s;
        end else if (hdr_sid == st_sid) begin
            if (st_eos) begin
                cls = STALE;
            end else if (hdr_seq_num == st_exp) begin
                cls     = OK;
                nxt_exp = end_s;
            end else if (hdr_seq_num > st_exp) begin
                cls     = MISS_SEQ;
                nxt_exp = end_s;
            end else begin
                // Partial overlap with new messages still moves us forward.
                cls = DUP;
                if (end_s > st_exp) begin
                    nxt_exp = end_s;
                end else begin
                    nxt_exp = st_exp;
                end
            end
        end else if (hdr_sid > st_sid) begin
            if (rollover_s) begin
                cls = OK;
            end else begin
                cls = MISS_SID;
            end
            base_eos_s = 1'b0;
            nxt_sid    = hdr_sid;
            nxt_exp    = end_s;
        end else begin
            cls = STALE;
        end
    end

    // An accepted EOS packet closes the channel's session.
    always_comb begin
        nxt_eos = base_eos_s | (hdr_eos & cls_accepts(cls));
    end

endmodule

// File: rtl/moldudp64_miss_det_mc.sv
// Multi-channel MoldUDP64 gap/session tracker: per-channel expected
// session/sequence state, one header classified per cycle, registered
// miss/jump/stale/dup/eos reports one cycle later.
module moldudp64_miss_det_mc
    import moldudp64_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int              SID_W       = DEF_SID_W,
    parameter int              SEQ_NUM_W   = DEF_SEQ_NUM_W,
    parameter int              ML_W        = DEF_ML_W,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = ML_W'(DEF_EOS_MSG_CNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdr_v_i,
    input  logic [CH_W-1:0]      hdr_ch_i,
    input  logic [SID_W-1:0]     hdr_sid_i,
    input  logic [SEQ_NUM_W-1:0] hdr_seq_num_i,
    input  logic [ML_W-1:0]      hdr_msg_cnt_i,
    input  logic                 clr_v_i,
    input  logic [CH_W-1:0]      clr_ch_i,
    output logic                 miss_seq_num_v_o,
    output logic [CH_W-1:0]      miss_seq_num_ch_o,
    output logic [SID_W-1:0]     miss_seq_num_sid_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
    output logic                 miss_sid_v_o,
    output logic [CH_W-1:0]      miss_sid_ch_o,
    output logic [SID_W-1:0]     miss_sid_start_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
    output logic [SID_W-1:0]     miss_sid_cnt_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o,
    output logic                 stale_v_o,
    output logic                 dup_v_o,
    output logic                 eos_v_o
);

    // Channel state register file.
    logic                 vld_r [N_CH];
    logic                 eos_r [N_CH];
    logic [SID_W-1:0]     sid_r [N_CH];
    logic [SEQ_NUM_W-1:0] exp_r [N_CH];

    logic [N_CH-1:0]      hsel_s;
    logic [N_CH-1:0]      csel_s;
    logic                 ch_ok_s;
    logic                 hdr_act_s;
    logic                 clr_hit_s;
    logic                 rd_vld_s;
    logic                 rd_eos_s;
    logic [SID_W-1:0]     rd_sid_s;
    logic [SEQ_NUM_W-1:0] rd_exp_s;
    logic                 st_vld_s;
    logic                 st_eos_s;

    hdr_cls_e             cls_s;
    logic                 hdr_eos_s;
    logic                 nxt_eos_s;
    logic [SID_W-1:0]     nxt_sid_s;
    logic [SEQ_NUM_W-1:0] nxt_exp_s;
    logic [SEQ_NUM_W-1:0] seq_gap_s;
    logic [SID_W-1:0]     sid_gap_s;

    logic                 ev_miss_seq_s;
    logic                 ev_miss_sid_s;
    logic                 ev_stale_s;
    logic                 ev_dup_s;
    logic                 ev_eos_s;

    // One-hot channel decodes for the header and the clear request.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            hsel_s[i] = (hdr_ch_i == CH_W'(i));
            csel_s[i] = (clr_ch_i == CH_W'(i));
        end
        ch_ok_s   = ({1'b0, hdr_ch_i} < (CH_W + 1)'(N_CH));
        hdr_act_s = hdr_v_i & ch_ok_s;
        clr_hit_s = clr_v_i & (clr_ch_i == hdr_ch_i);
    end

    // Read mux of the addressed channel's state (AND-OR over the one-hot select).
    always_comb begin
        rd_vld_s = 1'b0;
        rd_eos_s = 1'b0;
        rd_sid_s = {SID_W{1'b0}};
        rd_exp_s = {SEQ_NUM_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            rd_vld_s = rd_vld_s | (vld_r[i] & hsel_s[i]);
            rd_eos_s = rd_eos_s | (eos_r[i] & hsel_s[i]);
            rd_sid_s = rd_sid_s | (sid_r[i] & {SID_W{hsel_s[i]}});
            rd_exp_s = rd_exp_s | (exp_r[i] & {SEQ_NUM_W{hsel_s[i]}});
        end
        // A clear aimed at the same channel wins: the header sees no state.
        st_vld_s = rd_vld_s & ~clr_hit_s;
        st_eos_s = rd_eos_s & ~clr_hit_s;
    end

    moldudp64_hdr_cmp #(
        .SID_W       (SID_W),
        .SEQ_NUM_W   (SEQ_NUM_W),
        .ML_W        (ML_W),
        .EOS_MSG_CNT (EOS_MSG_CNT)
    ) u_hdr_cmp (
        .st_vld      (st_vld_s),
        .st_eos      (st_eos_s),
        .st_sid      (rd_sid_s),
        .st_exp      (rd_exp_s),
        .hdr_sid     (hdr_sid_i),
        .hdr_seq_num (hdr_seq_num_i),
        .hdr_msg_cnt (hdr_msg_cnt_i),
        .cls         (cls_s),
        .hdr_eos     (hdr_eos_s),
        .nxt_eos     (nxt_eos_s),
        .nxt_sid     (nxt_sid_s),
        .nxt_exp     (nxt_exp_s),
        .seq_gap     (seq_gap_s),
        .sid_gap     (sid_gap_s)
    );

    // Report strobes for the current header; at most one of the first four fires.
    always_comb begin
        ev_miss_seq_s = hdr_act_s & (cls_s == MISS_SEQ);
        ev_miss_sid_s = hdr_act_s & (cls_s == MISS_SID);
        ev_stale_s    = hdr_act_s & (cls_s == STALE);
        ev_dup_s      = hdr_act_s & (cls_s == DUP);
        ev_eos_s      = hdr_act_s & hdr_eos_s & cls_accepts(cls_s);
    end

    // Channel state update: header write has priority over a clear of the same channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                vld_r[i] <= 1'b0;
                eos_r[i] <= 1'b0;
                sid_r[i] <= {SID_W{1'b0}};
                exp_r[i] <= {SEQ_NUM_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (hdr_act_s && hsel_s[i]) begin
                    vld_r[i] <= 1'b1;
                    eos_r[i] <= nxt_eos_s;
                    sid_r[i] <= nxt_sid_s;
                    exp_r[i] <= nxt_exp_s;
                end else if (clr_v_i && csel_s[i]) begin
                    vld_r[i] <= 1'b0;
                    eos_r[i] <= 1'b0;
                end
            end
        end
    end

    // Registered reports; data fields load with their strobe and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_seq_num_v_o         <= 1'b0;
            miss_seq_num_ch_o        <= {CH_W{1'b0}};
            miss_seq_num_sid_o       <= {SID_W{1'b0}};
            miss_seq_num_start_o     <= {SEQ_NUM_W{1'b0}};
            miss_seq_num_cnt_o       <= {SEQ_NUM_W{1'b0}};
            miss_sid_v_o             <= 1'b0;
            miss_sid_ch_o            <= {CH_W{1'b0}};
            miss_sid_start_o         <= {SID_W{1'b0}};
            miss_sid_seq_num_start_o <= {SEQ_NUM_W{1'b0}};
            miss_sid_cnt_o           <= {SID_W{1'b0}};
            miss_sid_seq_num_end_o   <= {SEQ_NUM_W{1'b0}};
            stale_v_o                <= 1'b0;
            dup_v_o                  <= 1'b0;
            eos_v_o                  <= 1'b0;
        end else begin
            miss_seq_num_v_o <= ev_miss_seq_s;
            miss_sid_v_o     <= ev_miss_sid_s;
            stale_v_o        <= ev_stale_s;
            dup_v_o          <= ev_dup_s;
            eos_v_o          <= ev_eos_s;
            if (ev_miss_seq_s) begin
                miss_seq_num_ch_o    <= hdr_ch_i;
                miss_seq_num_sid_o   <= hdr_sid_i;
                miss_seq_num_start_o <= rd_exp_s;
                miss_seq_num_cnt_o   <= seq_gap_s;
            end
            if (ev_miss_sid_s) begin
                miss_sid_ch_o            <= hdr_ch_i;
                miss_sid_start_o         <= rd_sid_s;
                miss_sid_seq_num_start_o <= rd_exp_s;
                miss_sid_cnt_o           <= sid_gap_s;
                miss_sid_seq_num_end_o   <= hdr_seq_num_i;
            end
        end
    end

endmodule

// File: tb/tb_moldudp64_miss_det_mc.sv
// Self-checking bench for moldudp64_miss_det_mc: directed scenarios plus
// randomized back-to-back traffic against a per-channel reference model.
module tb_moldudp64_miss_det_mc;

    logic         clk = 1'b0;
    logic         reset;
    logic         hdr_v_i;
    logic [1:0]   hdr_ch_i;
    logic [79:0]  hdr_sid_i;
    logic [63:0]  hdr_seq_num_i;
    logic [15:0]  hdr_msg_cnt_i;
    logic         clr_v_i;
    logic [1:0]   clr_ch_i;
    logic         miss_seq_num_v_o;
    logic [1:0]   miss_seq_num_ch_o;
    logic [79:0]  miss_seq_num_sid_o;
    logic [63:0]  miss_seq_num_start_o;
    logic [63:0]  miss_seq_num_cnt_o;
    logic         miss_sid_v_o;
    logic [1:0]   miss_sid_ch_o;
    logic [79:0]  miss_sid_start_o;
    logic [63:0]  miss_sid_seq_num_start_o;
    logic [79:0]  miss_sid_cnt_o;
    logic [63:0]  miss_sid_seq_num_end_o;
    logic         stale_v_o;
    logic         dup_v_o;
    logic         eos_v_o;

    int n_checks = 0;
    int n_errors = 0;

    moldudp64_miss_det_mc dut (
        .clk                      (clk),
        .reset                    (reset),
        .hdr_v_i                  (hdr_v_i),
        .hdr_ch_i                 (hdr_ch_i),
        .hdr_sid_i                (hdr_sid_i),
        .hdr_seq_num_i            (hdr_seq_num_i),
        .hdr_msg_cnt_i            (hdr_msg_cnt_i),
        .clr_v_i                  (clr_v_i),
        .clr_ch_i                 (clr_ch_i),
        .miss_seq_num_v_o         (miss_seq_num_v_o),
        .miss_seq_num_ch_o        (miss_seq_num_ch_o),
        .miss_seq_num_sid_o       (miss_seq_num_sid_o),
        .miss_seq_num_start_o     (miss_seq_num_start_o),
        .miss_seq_num_cnt_o       (miss_seq_num_cnt_o),
        .miss_sid_v_o             (miss_sid_v_o),
        .miss_sid_ch_o            (miss_sid_ch_o),
        .miss_sid_start_o         (miss_sid_start_o),
        .miss_sid_seq_num_start_o (miss_sid_seq_num_start_o),
        .miss_sid_cnt_o           (miss_sid_cnt_o),
        .miss_sid_seq_num_end_o   (miss_sid_seq_num_end_o),
        .stale_v_o                (stale_v_o),
        .dup_v_o                  (dup_v_o),
        .eos_v_o                  (eos_v_o)
    );

    always #5 clk = ~clk;

    // Observed outputs grouped: flags {miss_seq, miss_sid, stale, dup, eos}.
    logic [4:0]   o_flg;
    logic [209:0] o_ms;
    logic [289:0] o_sj;
    assign o_flg = {miss_seq_num_v_o, miss_sid_v_o, stale_v_o, dup_v_o, eos_v_o};
    assign o_ms  = {miss_seq_num_ch_o, miss_seq_num_sid_o, miss_seq_num_start_o, miss_seq_num_cnt_o};
    assign o_sj  = {miss_sid_ch_o, miss_sid_start_o, miss_sid_seq_num_start_o,
                    miss_sid_cnt_o, miss_sid_seq_num_end_o};

    // Reference model: per-channel session knowledge and expected outputs.
    logic         m_vld [4];
    logic         m_eos [4];
    logic [79:0]  m_sid [4];
    logic [63:0]  m_exp [4];
    logic [4:0]   e_flg;
    logic [209:0] e_ms;
    logic [289:0] e_sj;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 1'b0;
            m_eos[i] = 1'b0;
            m_sid[i] = 80'd0;
            m_exp[i] = 64'd0;
        end
        e_flg = 5'd0;
        e_ms  = 210'd0;
        e_sj  = 290'd0;
    endtask

    task automatic model_step(input logic hv, input logic [1:0] ch, input logic [79:0] sid,
                              input logic [63:0] seq, input logic [15:0] cnt,
                              input logic cv, input logic [1:0] cch);
        logic [63:0] endv;
        logic        accepted;
        e_flg = 5'd0;
        if (cv) begin
            m_vld[cch] = 1'b0;
            m_eos[cch] = 1'b0;
        end
        if (hv) begin
            endv     = seq + ((cnt == 16'hffff) ? 64'd0 : {48'd0, cnt});
            accepted = 1'b1;
            if (!m_vld[ch]) begin
                m_vld[ch] = 1'b1;
                m_sid[ch] = sid;
                m_exp[ch] = endv;
                m_eos[ch] = 1'b0;
            end else if (sid < m_sid[ch] || (sid == m_sid[ch] && m_eos[ch])) begin
                e_flg[2] = 1'b1;
                accepted = 1'b0;
            end else if (sid > m_sid[ch]) begin
                if (!(m_eos[ch] && sid == m_sid[ch] + 80'd1 && seq == 64'd1)) begin
                    e_flg[3] = 1'b1;
                    e_sj = {ch, m_sid[ch], m_exp[ch], sid - m_sid[ch], seq};
                end
                m_sid[ch] = sid;
                m_exp[ch] = endv;
                m_eos[ch] = 1'b0;
            end else if (seq > m_exp[ch]) begin
                e_flg[4] = 1'b1;
                e_ms = {ch, sid, m_exp[ch], seq - m_exp[ch]};
                m_exp[ch] = endv;
            end else if (seq < m_exp[ch]) begin
                e_flg[1] = 1'b1;
                if (endv > m_exp[ch]) m_exp[ch] = endv;
            end else begin
                m_exp[ch] = endv;
            end
            if (accepted && cnt == 16'hffff) begin
                m_eos[ch] = 1'b1;
                e_flg[0]  = 1'b1;
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, sample #1 after the edge.
    task automatic drive(input logic hv, input logic [1:0] ch, input logic [79:0] sid,
                         input logic [63:0] seq, input logic [15:0] cnt,
                         input logic cv, input logic [1:0] cch);
        hdr_v_i       = hv;
        hdr_ch_i      = ch;
        hdr_sid_i     = sid;
        hdr_seq_num_i = seq;
        hdr_msg_cnt_i = cnt;
        clr_v_i       = cv;
        clr_ch_i      = cch;
        model_step(hv, ch, sid, seq, cnt, cv, cch);
        @(posedge clk);
        #1;
        hdr_v_i = 1'b0;
        clr_v_i = 1'b0;
    endtask

    task automatic gen_and_drive(input bit force_en, input logic [1:0] force_ch);
        logic [1:0]  ch;
        logic [1:0]  cch;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        hv;
        logic        cv;
        int          r;
        ch  = force_en ? force_ch : 2'($urandom_range(0, 3));
        hv  = force_en ? 1'b1 : ($urandom_range(0, 9) != 0);
        cv  = ($urandom_range(0, 19) == 0);
        cch = 2'($urandom_range(0, 3));
        r   = $urandom_range(0, 9);
        if (!m_vld[ch])  sid = 80'($urandom_range(0, 20));
        else if (r == 0) sid = m_sid[ch] - 80'd1;
        else if (r <= 2) sid = m_sid[ch] + 80'($urandom_range(1, 3));
        else if (r == 3) sid = m_sid[ch] + 80'd1;
        else             sid = m_sid[ch];
        seq = (r == 3) ? 64'd1 : m_exp[ch] + 64'($urandom_range(0, 6)) - 64'd3;
        r   = $urandom_range(0, 9);
        cnt = (r == 0) ? 16'hffff : (r == 1) ? 16'd0 : 16'($urandom_range(1, 5));
        drive(hv, ch, sid, seq, cnt, cv, cch);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hdr_v_i = 1'b0; hdr_ch_i = 2'd0; hdr_sid_i = 80'd0; hdr_seq_num_i = 64'd0;
        hdr_msg_cnt_i = 16'd0; clr_v_i = 1'b0; clr_ch_i = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (o_flg !== 5'd0) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 00000", o_flg);
        end
        n_checks++;
        if (o_ms !== 210'd0) begin
            n_errors++; $display("FAIL reset_miss_seq_data: got %h expected 0", o_ms);
        end
        n_checks++;
        if (o_sj !== 290'd0) begin
            n_errors++; $display("FAIL reset_miss_sid_data: got %h expected 0", o_sj);
        end
    endtask

    typedef struct packed {
        logic [1:0]  ch;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        clr;
        logic [4:0]  flg;
    } step_t;

    task automatic test_directed();
        step_t tab [19];
        tab = '{
            '{2'd0, 80'hDEADBEEF, 64'd1,  16'd3,    1'b0, 5'b00000},
            '{2'd0, 80'hDEADBEEF, 64'd4,  16'd2,    1'b0, 5'b00000},
            '{2'd0, 80'hDEADBEEF, 64'd10, 16'd1,    1'b0, 5'b10000},
            '{2'd1, 80'd5,        64'd20, 16'd1,    1'b0, 5'b00000},
            '{2'd1, 80'd8,        64'd1,  16'd1,    1'b0, 5'b01000},
            '{2'd2, 80'd7,        64'd1,  16'd4,    1'b0, 5'b00000},
            '{2'd2, 80'd7,        64'd3,  16'd4,    1'b0, 5'b00010},
            '{2'd2, 80'd7,        64'd7,  16'd0,    1'b0, 5'b00000},
            '{2'd2, 80'd6,        64'd7,  16'd1,    1'b0, 5'b00100},
            '{2'd3, 80'd9,        64'd1,  16'hffff, 1'b0, 5'b00001},
            '{2'd3, 80'd9,        64'd1,  16'd1,    1'b0, 5'b00100},
            '{2'd3, 80'd10,       64'd1,  16'd2,    1'b0, 5'b00000},
            '{2'd3, 80'd10,       64'd3,  16'd0,    1'b0, 5'b00000},
            '{2'd0, 80'hDEADBEEF, 64'd11, 16'hffff, 1'b0, 5'b00001},
            '{2'd0, 80'hDEADBEF1, 64'd5,  16'd1,    1'b0, 5'b01000},
            '{2'd1, 80'd8,        64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 1'b0, 5'b10000},
            '{2'd1, 80'd8,        64'd1,  16'd1,    1'b0, 5'b00000},
            '{2'd0, 80'd3,        64'd1,  16'd1,    1'b1, 5'b00000},
            '{2'd0, 80'd3,        64'd2,  16'd1,    1'b0, 5'b00000}
        };
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, tab[i].ch, tab[i].sid, tab[i].seq, tab[i].cnt, tab[i].clr, tab[i].ch);
            n_checks++;
            if (o_flg !== tab[i].flg) begin
                n_errors++; $display("FAIL dir_flags step %0d: got %b expected %b", i, o_flg, tab[i].flg);
            end
            n_checks++;
            if (o_ms !== e_ms) begin
                n_errors++; $display("FAIL dir_miss_seq_data step %0d: got %h expected %h", i, o_ms, e_ms);
            end
            n_checks++;
            if (o_sj !== e_sj) begin
                n_errors++; $display("FAIL dir_miss_sid_data step %0d: got %h expected %h", i, o_sj, e_sj);
            end
            if (i == 2) begin
                n_checks++;
                if (miss_seq_num_start_o !== 64'd6 || miss_seq_num_cnt_o !== 64'd4 ||
                    miss_seq_num_sid_o !== 80'hDEADBEEF || miss_seq_num_ch_o !== 2'd0) begin
                    n_errors++;
                    $display("FAIL dir_gap_fields: got start=%0d cnt=%0d sid=%h expected start=6 cnt=4 sid=deadbeef",
                             miss_seq_num_start_o, miss_seq_num_cnt_o, miss_seq_num_sid_o);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (miss_sid_start_o !== 80'd5 || miss_sid_seq_num_start_o !== 64'd21 ||
                    miss_sid_cnt_o !== 80'd3 || miss_sid_seq_num_end_o !== 64'd1 || miss_sid_ch_o !== 2'd1) begin
                    n_errors++;
                    $display("FAIL dir_sid_jump_fields: got start=%0d sstart=%0d cnt=%0d end=%0d expected 5 21 3 1",
                             miss_sid_start_o, miss_sid_seq_num_start_o, miss_sid_cnt_o, miss_sid_seq_num_end_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 530; i++) begin
            if (i < 30) begin
                gen_and_drive(1'b1, ((i % 3) == 2) ? 2'd1 : 2'd0);
            end else begin
                gen_and_drive(1'b0, 2'd0);
            end
            n_checks++;
            if (o_flg !== e_flg) begin
                n_errors++; $display("FAIL b2b_flags cycle %0d: got %b expected %b", i, o_flg, e_flg);
            end
            n_checks++;
            if (o_ms !== e_ms) begin
                n_errors++; $display("FAIL b2b_miss_seq_data cycle %0d: got %h expected %h", i, o_ms, e_ms);
            end
            n_checks++;
            if (o_sj !== e_sj) begin
                n_errors++; $display("FAIL b2b_miss_sid_data cycle %0d: got %h expected %h", i, o_sj, e_sj);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 2'd1, 80'd50, 64'd100, 16'd2, 1'b0, 2'd0);
        drive(1'b1, 2'd1, 80'd50, 64'd110, 16'd1, 1'b0, 2'd0);
        // Reset with a would-be stale header in flight.
        reset = 1'b1;
        hdr_v_i = 1'b1; hdr_ch_i = 2'd1; hdr_sid_i = 80'd40;
        hdr_seq_num_i = 64'd1; hdr_msg_cnt_i = 16'd1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        hdr_v_i = 1'b0;
        n_checks++;
        if ({o_flg, o_ms, o_sj} !== 505'd0) begin
            n_errors++; $display("FAIL midreset_outputs: got flags %b expected all zero outputs", o_flg);
        end
        // Lower sid than before reset: must recapture silently.
        drive(1'b1, 2'd1, 80'd40, 64'd1, 16'd1, 1'b0, 2'd0);
        n_checks++;
        if (o_flg !== 5'b00000) begin
            n_errors++; $display("FAIL midreset_recapture: got %b expected 00000", o_flg);
        end
        drive(1'b1, 2'd1, 80'd40, 64'd5, 16'd1, 1'b0, 2'd0);
        n_checks++;
        if (o_flg !== 5'b10000 || miss_seq_num_start_o !== 64'd2 || miss_seq_num_cnt_o !== 64'd3) begin
            n_errors++;
            $display("FAIL midreset_gap: got flags %b start=%0d cnt=%0d expected 10000 start=2 cnt=3",
                     o_flg, miss_seq_num_start_o, miss_seq_num_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
